rv32im_decode_stage: RTL and testbench
======================================

RV32IM_DECODE_STAGE -- requirements
Module: rv32im_decode_stage

Interface
REQ-001 Parameter M_EXT, default 1: 1 = decode the M-extension (funct7=0000001 in OP); 0 = M encodings flagged illegal.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  discard all held instructions (redirect from downstream).
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_ready  out  1  stage can accept (registered).
REQ-007 in_instr  in  32  raw instruction word, RV32IM format union (raw view).
REQ-008 in_pc  in  32  instruction address.
REQ-009 out_valid  out  1  decoded instruction held on outputs.
REQ-010 out_ready  in  1  downstream consumes.
REQ-011 out_pc  out  32  pc of held instruction.
REQ-012 out_rd / out_rs1 / out_rs2  out  5 each  raw register fields (bits 11:7, 19:15, 24:20).
REQ-013 out_funct3  out  3  bits 14:12.
REQ-014 out_imm  out  32  sign-extended immediate per format.
REQ-015 out_opclass  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL.
REQ-016 out_is_m  out  1  legal M-extension op.
REQ-017 out_wen  out  1  writes rd.
REQ-018 out_illegal  out  1  illegal encoding.

Function
REQ-019 Decode is combinational on in_instr; results captured into a 2-entry buffer (output register + skid register); latency 1 cycle from accept to out_valid.
REQ-020 Accept = in_valid && in_ready; in_ready = !skid_valid, registered.
REQ-021 On accept: out register loads if out register empty or out_ready=1 that cycle; otherwise skid register loads.
REQ-022 Output handshake (out_valid && out_ready) with skid_valid=1: skid moves to out register next edge, skid_valid clears; any simultaneous accept goes into skid.
REQ-023 Output handshake with skid empty and no accept: out_valid clears next edge.
REQ-024 Order strictly preserved; no drop, no duplication; outputs stable while out_valid && !out_ready.
REQ-025 Immediates: I = sext(bits 31:20); S = sext({31:25,11:7}); B = sext({31,7,30:25,11:8,0}); U = {31:12,12'b0}; J = sext({31,19:12,20,30:21,0}); OP/FENCE/SYSTEM/illegal -> 0.
REQ-026 Illegal when: bits 1:0 != 11; unknown opcode; JALR funct3!=0; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 >= 011; OP funct7 not in {0000000, 0100000 with funct3 000/101, 0000001 if M_EXT}; OP_IMM SLLI funct7!=0, SRLI/SRAI funct7 not 0000000/0100000.
REQ-027 Illegal instructions still flow: opclass=15, out_illegal=1, out_wen=0, out_is_m=0, out_imm=0.
REQ-028 out_wen = 1 iff rd!=0 and opclass in {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP}.
REQ-029 flush: both valids clear next edge; accept in flush cycle discarded; in_ready=1 next cycle.
REQ-030 flush and reset dominate all handshake events in the same cycle.

Reset
REQ-031 While reset=1 at an edge: out_valid=0, skid_valid=0, in_ready=1 next cycle; all output data fields 0, out_opclass=0.
REQ-032 Reset asserted mid-transfer: held instructions lost, no partial output.

Verification
REQ-033 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, opclass=7, wen=1.
REQ-034 0x022081B3 (mul x3,x1,x2) -> opclass=8, is_m=1, wen=1; with M_EXT=0 -> opclass=15, illegal=1, wen=0.
REQ-035 0xFFDFF06F (jal x0,-4) -> opclass=2, imm=0xFFFFFFFC, wen=0; 0x00000000 -> illegal=1.
REQ-036 out_ready=0, three back-to-back in_valid words A,B,C -> A,B accepted, in_ready=0 holding C; out_ready=1 -> A,B,C emitted in order on consecutive cycles.
REQ-037 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed word never appears.
REQ-038 reset=1 asserted with both entries full -> next cycle out_valid=0, in_ready=1, all data outputs 0.

Source files
------------

// File: rtl/rv32im_decode_stage.sv
// RV32IM decode stage: combinational decode of the fetched word into a
// two-entry (output + skid) buffer with registered in_ready.
module rv32im_decode_stage #(
   parameter bit M_EXT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [2:0]  out_funct3,
   output logic [31:0] out_imm,
   output logic [3:0]  out_opclass,
   output logic        out_is_m,
   output logic        out_wen,
   output logic        out_illegal
);

   localparam logic [3:0] CL_LUI = 4'd0, CL_AUIPC = 4'd1, CL_JAL = 4'd2, CL_JALR = 4'd3,
                          CL_BRANCH = 4'd4, CL_LOAD = 4'd5, CL_STORE = 4'd6, CL_OP_IMM = 4'd7,
                          CL_OP = 4'd8, CL_FENCE = 4'd9, CL_SYSTEM = 4'd10, CL_ILLEGAL = 4'd15;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [3:0]  opclass;
      logic        is_m;
      logic        wen;
      logic        illegal;
   } dec_t;

   dec_t       dec;
   dec_t       out_q, out_n, skid_q, skid_n;
   logic       out_valid_q, out_valid_n, skid_valid_q, skid_valid_n, in_ready_q;
   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.rd      = in_instr[11:7];
      dec.rs1     = in_instr[19:15];
      dec.rs2     = in_instr[24:20];
      dec.funct3  = f3;
      dec.opclass = CL_ILLEGAL;
      case (opcode)
         7'b0110111: begin dec.opclass = CL_LUI;   dec.imm = imm_u; end
         7'b0010111: begin dec.opclass = CL_AUIPC; dec.imm = imm_u; end
         7'b1101111: begin dec.opclass = CL_JAL;   dec.imm = imm_j; end
         7'b1100111: begin
            dec.opclass = CL_JALR; dec.imm = imm_i;
            dec.illegal = (f3 != 3'b000);
         end
         7'b1100011: begin
            dec.opclass = CL_BRANCH; dec.imm = imm_b;
            dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b0000011: begin
            dec.opclass = CL_LOAD; dec.imm = imm_i;
            dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin
            dec.opclass = CL_STORE; dec.imm = imm_s;
            dec.illegal = (f3 >= 3'b011);
         end
         7'b0010011: begin
            dec.opclass = CL_OP_IMM; dec.imm = imm_i;
            if (f3 == 3'b001)      dec.illegal = (f7 != 7'b0000000);
            else if (f3 == 3'b101) dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         7'b0110011: begin
            dec.opclass = CL_OP;
            if (f7 == 7'b0000000) dec.illegal = 1'b0;
            else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) dec.illegal = 1'b0;
            else if (f7 == 7'b0000001 && M_EXT) dec.is_m = 1'b1;
            else dec.illegal = 1'b1;
         end
         7'b0001111: dec.opclass = CL_FENCE;
         7'b1110011: dec.opclass = CL_SYSTEM;
         default:    dec.illegal = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) dec.illegal = 1'b1;
      // Illegal words still flow downstream, but carry no side effects.
      if (dec.illegal) begin
         dec.opclass = CL_ILLEGAL;
         dec.imm     = '0;
         dec.is_m    = 1'b0;
      end
      dec.wen = !dec.illegal && (dec.rd != 5'd0) &&
                (dec.opclass inside {CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_OP_IMM, CL_OP});
   end

   // Handshake: a word moves when valid && ready are both high at a rising edge.
   // in_ready is registered (!skid_valid next); outputs hold while out_valid && !out_ready.
   logic accept, out_fire;
   assign accept   = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      out_n        = out_q;
      skid_n       = skid_q;
      out_valid_n  = out_valid_q;
      skid_valid_n = skid_valid_q;
      if (flush) begin
         out_valid_n  = 1'b0;
         skid_valid_n = 1'b0;
      end else if (out_fire && skid_valid_q) begin
         out_n        = skid_q;
         skid_valid_n = accept;
         if (accept) skid_n = dec;
      end else if (accept) begin
         if (!out_valid_q || out_ready) begin
            out_n       = dec;
            out_valid_n = 1'b1;
         end else begin
            skid_n       = dec;
            skid_valid_n = 1'b1;
         end
      end else if (out_fire) begin
         out_valid_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_n;
         skid_q       <= skid_n;
         out_valid_q  <= out_valid_n;
         skid_valid_q <= skid_valid_n;
         in_ready_q   <= !skid_valid_n;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = out_q.pc;
   assign out_rd      = out_q.rd;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_funct3  = out_q.funct3;
   assign out_imm     = out_q.imm;
   assign out_opclass = out_q.opclass;
   assign out_is_m    = out_q.is_m;
   assign out_wen     = out_q.wen;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Directed bench for rv32im_decode_stage: decode vectors, skid buffering,
// flush and reset, against hand-computed expectations.
module tb_rv32im_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_is_m, out_wen, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;
   logic [3:0]  out_opclass;

   logic        m0_in_ready, m0_out_valid, m0_is_m, m0_wen, m0_illegal;
   logic [31:0] m0_pc, m0_imm;
   logic [4:0]  m0_rd, m0_rs1, m0_rs2;
   logic [2:0]  m0_funct3;
   logic [3:0]  m0_opclass;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rv32im_decode_stage #(.M_EXT(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_imm(out_imm), .out_opclass(out_opclass),
      .out_is_m(out_is_m), .out_wen(out_wen), .out_illegal(out_illegal)
   );

   rv32im_decode_stage #(.M_EXT(1'b0)) dut_m0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
      .out_pc(m0_pc), .out_rd(m0_rd), .out_rs1(m0_rs1), .out_rs2(m0_rs2),
      .out_funct3(m0_funct3), .out_imm(m0_imm), .out_opclass(m0_opclass),
      .out_is_m(m0_is_m), .out_wen(m0_wen), .out_illegal(m0_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-word transfer into an empty stage with out_ready=1; decoded word is visible after one edge.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [3:0]  opclass;
      logic [4:0]  rd;
      logic        wen;
      logic        illegal;
      logic        is_m;
   } vec_t;

   vec_t vecs[$];

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      tick(); tick();
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_in_ready",  {31'b0, in_ready}, 32'd1);
      check("reset_opclass",   {28'b0, out_opclass}, 32'd0);
      check("reset_imm",       out_imm, 32'd0);
      reset = 1'b0;
      tick();

      // addi x1,x0,-1 with field-level checks
      send(32'hFFF00093, 32'h0000_1000);
      check("addi_valid",   {31'b0, out_valid}, 32'd1);
      check("addi_rd",      {27'b0, out_rd}, 32'd1);
      check("addi_rs1",     {27'b0, out_rs1}, 32'd0);
      check("addi_imm",     out_imm, 32'hFFFFFFFF);
      check("addi_opclass", {28'b0, out_opclass}, 32'd7);
      check("addi_wen",     {31'b0, out_wen}, 32'd1);
      check("addi_pc",      out_pc, 32'h0000_1000);

      // mul x3,x1,x2 on both parameterisations
      send(32'h022081B3, 32'h0000_1004);
      check("mul_opclass",    {28'b0, out_opclass}, 32'd8);
      check("mul_is_m",       {31'b0, out_is_m}, 32'd1);
      check("mul_wen",        {31'b0, out_wen}, 32'd1);
      check("mul_rs2",        {27'b0, out_rs2}, 32'd2);
      check("m0_mul_opclass", {28'b0, m0_opclass}, 32'd15);
      check("m0_mul_illegal", {31'b0, m0_illegal}, 32'd1);
      check("m0_mul_wen",     {31'b0, m0_wen}, 32'd0);

      //          instr          imm           cls   rd  wen  ill  m
      vecs.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, 4'd2,  5'd0, 1'b0, 1'b0, 1'b0}); // jal x0,-4
      vecs.push_back('{32'h00000000, 32'h00000000, 4'd15, 5'd0, 1'b0, 1'b1, 1'b0}); // all zero
      vecs.push_back('{32'h123452B7, 32'h12345000, 4'd0,  5'd5, 1'b1, 1'b0, 1'b0}); // lui x5
      vecs.push_back('{32'h0020A423, 32'h00000008, 4'd6,  5'd8, 1'b0, 1'b0, 1'b0}); // sw x2,8(x1)
      vecs.push_back('{32'hFE000CE3, 32'hFFFFFFF8, 4'd4,  5'd25, 1'b0, 1'b0, 1'b0}); // beq -8
      vecs.push_back('{32'h40009093, 32'h00000000, 4'd15, 5'd1, 1'b0, 1'b1, 1'b0}); // slli bad f7
      vecs.push_back('{32'h0000B083, 32'h00000000, 4'd15, 5'd1, 1'b0, 1'b1, 1'b0}); // load f3=011
      foreach (vecs[i]) begin
         send(vecs[i].instr, 32'h2000 + 32'(i) * 4);
         check($sformatf("v%0d_opclass", i), {28'b0, out_opclass}, {28'b0, vecs[i].opclass});
         check($sformatf("v%0d_imm", i),     out_imm, vecs[i].imm);
         check($sformatf("v%0d_rd", i),      {27'b0, out_rd}, {27'b0, vecs[i].rd});
         check($sformatf("v%0d_wen", i),     {31'b0, out_wen}, {31'b0, vecs[i].wen});
         check($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].illegal});
         check($sformatf("v%0d_is_m", i),    {31'b0, out_is_m}, {31'b0, vecs[i].is_m});
      end
      tick();
      check("drain_idle", {31'b0, out_valid}, 32'd0);

      // Back-to-back A,B,C with downstream stalled, then released
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00100093; in_pc = 32'h3000;
      tick();
      check("bb_a_valid", {31'b0, out_valid}, 32'd1);
      check("bb_a_ready", {31'b0, in_ready}, 32'd1);
      in_instr = 32'h00200113; in_pc = 32'h3004;
      tick();
      check("bb_b_ready", {31'b0, in_ready}, 32'd0);
      check("bb_hold_a",  out_imm, 32'd1);
      in_instr = 32'h00300193; in_pc = 32'h3008;
      tick();
      check("bb_c_held_ready", {31'b0, in_ready}, 32'd0);
      check("bb_stable_pc",    out_pc, 32'h3000);
      out_ready = 1'b1;
      tick();
      check("bb_out_b",   out_imm, 32'd2);
      check("bb_b_pc",    out_pc, 32'h3004);
      check("bb_b_ready_again", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("bb_out_c",   out_imm, 32'd3);
      check("bb_c_rd",    {27'b0, out_rd}, 32'd3);
      check("bb_c_valid", {31'b0, out_valid}, 32'd1);
      tick();
      check("bb_empty",   {31'b0, out_valid}, 32'd0);

      // Flush with a full buffer and an incoming word
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00100093; in_pc = 32'h4000;
      tick();
      in_instr = 32'h00200113; in_pc = 32'h4004;
      tick();
      check("fl_full", {31'b0, in_ready}, 32'd0);
      flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h4008;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("fl_out_valid", {31'b0, out_valid}, 32'd0);
      check("fl_in_ready",  {31'b0, in_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("fl_never_%0d", k), {31'b0, out_valid}, 32'd0);
      end

      // Reset with both entries full
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'hFFF00093; in_pc = 32'h5000;
      tick();
      in_instr = 32'h022081B3; in_pc = 32'h5004;
      tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b1;
      check("rs_out_valid", {31'b0, out_valid}, 32'd0);
      check("rs_in_ready",  {31'b0, in_ready}, 32'd1);
      check("rs_pc",        out_pc, 32'd0);
      check("rs_imm",       out_imm, 32'd0);
      check("rs_rd",        {27'b0, out_rd}, 32'd0);
      check("rs_opclass",   {28'b0, out_opclass}, 32'd0);
      tick();
      check("rs_no_leak",   {31'b0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
